// File: rtl/mux_pkg.sv
// mux_pkg: mode encodings, scan FSM states and a clog2 helper shared by the channel scanner.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic {IDLE, SCAN} scan_state_e;

    // Never narrower than one bit, so one-entry counters still get a real register.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/scan_counter.sv
// scan_counter: round-robin channel pointer with a dwell counter.
// clear_i zeroes the pointer for the current cycle; advance_i counts one capture.
module scan_counter
    import mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DWELL    = 1,
    localparam int SELW    = clog2(CHANNELS),
    localparam int DW      = clog2(DWELL)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            advance_i,
    input  logic            clear_i,
    output logic [SELW-1:0] ptr_o
);

    logic [SELW-1:0] ptr_q, ptr_d, ptr_b;
    logic [DW-1:0]   cnt_q, cnt_d, cnt_b;
    logic            wrap;

    always_comb begin
        ptr_b = clear_i ? '0 : ptr_q;
        cnt_b = clear_i ? '0 : cnt_q;
        wrap  = cnt_b == DW'(DWELL - 1);
        cnt_d = advance_i ? (wrap ? '0 : cnt_b + 1'b1) : cnt_b;
        ptr_d = (advance_i && wrap) ? ((ptr_b == SELW'(CHANNELS - 1)) ? '0 : ptr_b + 1'b1) : ptr_b;
    end

    assign ptr_o = ptr_b;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/channel_mux_scanner.sv
// channel_mux_scanner: manual or round-robin channel select into a one-entry
// valid/ready output register that never drops a held beat.
module channel_mux_scanner
    import mux_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 1,
    localparam int SELW    = clog2(CHANNELS)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      en_i,
    input  logic                      mode_i,
    input  logic [SELW-1:0]           sel_i,
    input  logic [CHANNELS*WIDTH-1:0] d_i,
    output logic [WIDTH-1:0]          q_o,
    output logic [SELW-1:0]           qch_o,
    output logic                      qvalid_o,
    input  logic                      qready_i
);

    scan_state_e     state_q, state_d;
    logic            free, cap, entry, adv;
    logic            mode_q, mode_d;
    logic [SELW-1:0] ptr, chan;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] q_q, q_d;
    logic [SELW-1:0] qch_q, qch_d;
    logic            qvalid_q, qvalid_d;

    assign free  = !qvalid_q || qready_i;
    assign cap   = free && en_i;
    // Previous mode only moves when the register is free, so a stalled entry is still seen afterwards.
    assign entry = free && mode_i == MODE_SCAN && mode_q == MODE_MANUAL;
    assign mode_d = free ? mode_i : mode_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = !free ? state_q : (en_i && mode_i == MODE_SCAN) ? SCAN : IDLE;
    end

    always_comb begin
        adv = free && state_d == SCAN;
    end

    scan_counter #(
        .CHANNELS (CHANNELS),
        .DWELL    (DWELL)
    ) u_scan_counter (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .advance_i (adv),
        .clear_i   (entry),
        .ptr_o     (ptr)
    );

    // Out-of-range manual selects fall through to zero.
    always_comb begin
        chan = mode_i == MODE_SCAN ? ptr : sel_i;
        word = '0;
        for (int k = 0; k < CHANNELS; k++)
            if (chan == SELW'(k)) word = d_i[k*WIDTH +: WIDTH];
        q_d      = cap ? word : q_q;
        qch_d    = cap ? chan : qch_q;
        qvalid_d = cap || (qvalid_q && !qready_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q      <= '0;
            qch_q    <= '0;
            qvalid_q <= 1'b0;
            mode_q   <= MODE_MANUAL;
        end else begin
            q_q      <= q_d;
            qch_q    <= qch_d;
            qvalid_q <= qvalid_d;
            mode_q   <= mode_d;
        end
    end

    assign q_o      = q_q;
    assign qch_o    = qch_q;
    assign qvalid_o = qvalid_q;

endmodule
